// File: rtl/store_rmw_if.sv
// Store request / word-memory bus between the MEM stage and store_rmw_unit.
// The master side drives the store request and supplies memory read data.
// The slave side is the store unit. It answers with stall/done status and
// drives the word-memory strobes.
interface store_rmw_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              done;
  logic              misalign_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;

  modport master (
    output req_valid, req_size, req_addr, req_wdata, mem_rdata,
    input  stall, done, misalign_err, mem_addr, mem_rd, mem_we, mem_wdata
  );

  modport slave (
    input  req_valid, req_size, req_addr, req_wdata, mem_rdata,
    output stall, done, misalign_err, mem_addr, mem_rd, mem_we, mem_wdata
  );
endinterface

// File: rtl/store_rmw_unit.sv
// Store-side data path for the MEM stage.
// Word stores go straight to a word-only memory.
// Byte and halfword stores use a read-modify-write sequence: RD, then MRG, then WR.
// Illegal sizes and misaligned accesses retire after one cycle with an error pulse.
module store_rmw_unit #(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  store_rmw_if.slave  bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] MRG  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              held_half;   // 1: halfword, 0: byte (only sub-word sizes reach MRG)
  logic [1:0]        held_lane;
  logic [15:0]       held_data;
  logic              done_flag;
  logic              err_flag;
  logic              rd_strobe;
  logic              we_strobe;
  logic [ADDR_W-1:0] addr_word;
  logic [31:0]       write_word;

  // Replace the addressed lane(s) of old_word. All other lanes pass through unchanged.
  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_word,
    input logic [15:0] new_data,
    input logic        is_half,
    input logic [1:0]  lane
  );
    logic [31:0] word;
    word = old_word;
    if (is_half) begin
      if (lane[1]) word[31:16] = new_data;
      else         word[15:0]  = new_data;
    end else begin
      case (lane)
        2'd0:    word[7:0]   = new_data[7:0];
        2'd1:    word[15:8]  = new_data[7:0];
        2'd2:    word[23:16] = new_data[7:0];
        2'd3:    word[31:24] = new_data[7:0];
        default: word        = old_word;
      endcase
    end
    return word;
  endfunction

  // Next-state decode. Size and alignment are classified when a request is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_size)
            SZ_BYTE: state_nxt = RD;
            SZ_HALF: state_nxt = bus.req_addr[0] ? ERR : RD;
            SZ_WORD: state_nxt = (bus.req_addr[1:0] != 2'b00) ? ERR : WR;
            default: state_nxt = ERR;
          endcase
        end else begin
          state_nxt = IDLE;
        end
      end
      RD:      state_nxt = MRG;
      MRG:     state_nxt = WR;
      WR:      state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  // Strobes are decoded from the next state, so each output is high exactly in its own state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      held_half  <= 1'b0;
      held_lane  <= 2'b00;
      held_data  <= 16'h0000;
      done_flag  <= 1'b0;
      err_flag   <= 1'b0;
      rd_strobe  <= 1'b0;
      we_strobe  <= 1'b0;
      addr_word  <= '0;
      write_word <= 32'h0000_0000;
    end else begin
      state     <= state_nxt;
      rd_strobe <= (state_nxt == RD);
      we_strobe <= (state_nxt == WR);
      done_flag <= (state_nxt == WR) || (state_nxt == ERR);
      err_flag  <= (state_nxt == ERR);
      if (state == IDLE && bus.req_valid) begin
        held_half <= (bus.req_size == SZ_HALF);
        held_lane <= bus.req_addr[1:0];
        held_data <= bus.req_wdata[15:0];
        addr_word <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        // An aligned word store skips the read and writes the request data directly.
        if (state_nxt == WR) write_word <= bus.req_wdata;
        else                 write_word <= write_word;
      end else if (state == MRG) begin
        write_word <= merge_lanes(bus.mem_rdata, held_data, held_half, held_lane);
      end else begin
        write_word <= write_word;
      end
    end
  end

  assign bus.stall        = bus.req_valid & ~done_flag;
  assign bus.done         = done_flag;
  assign bus.misalign_err = err_flag;
  assign bus.mem_rd       = rd_strobe;
  assign bus.mem_we       = we_strobe;
  assign bus.mem_addr     = addr_word;
  assign bus.mem_wdata    = write_word;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench for store_rmw_unit.
// A synchronous word memory model sits on the bus.
// Expected writes are queued when each store is driven, and are popped and compared on every mem_we.
module tb_store_rmw_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_rmw_if #(.ADDR_W(32)) bus ();

  store_rmw_unit #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:255];
  logic [63:0] exp_q [$];
  logic [63:0] exp_mon;
  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  int we_count = 0;
  int rd_count = 0;
  int last_done_cycle = 0;

  // Synchronous word memory: read data is valid the cycle after mem_rd.
  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  // Write monitor: score every mem_we against the queue, and reject rd and we in the same cycle.
  always @(negedge clk) begin
    if (bus.mem_rd === 1'b1) rd_count++;
    if (bus.mem_we === 1'b1) begin
      we_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
      end else begin
        exp_mon = exp_q.pop_front();
        if (bus.mem_addr !== exp_mon[63:32] || bus.mem_wdata !== exp_mon[31:0]) begin
          errors++;
          $display("FAIL write_data addr=%h data=%h expected addr=%h data=%h",
                   bus.mem_addr, bus.mem_wdata, exp_mon[63:32], exp_mon[31:0]);
        end
      end
    end
    if (bus.mem_rd === 1'b1 || bus.mem_we === 1'b1) begin
      checks++;
      if (bus.mem_rd === 1'b1 && bus.mem_we === 1'b1) begin
        errors++;
        $display("FAIL rd_we_overlap rd=%b we=%b expected not both", bus.mem_rd, bus.mem_we);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_word(input logic [31:0] old_word, input logic [1:0] size,
                                             input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] w;
    w = old_word;
    for (int i = 0; i < 4; i++) begin
      if (size == 2'b00 && i == int'(addr[1:0])) w[8*i +: 8] = wdata[7:0];
      if (size == 2'b01 && (i / 2) == int'(addr[1])) w[8*i +: 8] = wdata[8*(i%2) +: 8];
    end
    if (size == 2'b10) w = wdata;
    return w;
  endfunction

  function automatic bit is_legal(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b00) return 1'b1;
    if (size == 2'b01) return (addr[0] == 1'b0);
    if (size == 2'b10) return (addr[1:0] == 2'b00);
    return 1'b0;
  endfunction

  // Drive one request at the next edge and follow it cycle by cycle until done.
  // Returns at the negedge of the done cycle with req_valid still high.
  task automatic run_req(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input bit exp_err, input logic [31:0] exp_word,
                         input string name);
    int cyc;
    bit seen;
    bit exp_rd;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    if (!exp_err) exp_q.push_back({addr[31:2], 2'b00, exp_word});
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      checks++;
      if (bus.stall !== (cyc < exp_lat)) begin
        errors++;
        $display("FAIL %s_stall cycle %0d got %b expected %b", name, cyc, bus.stall, (cyc < exp_lat));
      end
      exp_rd = (exp_lat == 3 && cyc == 1);
      checks++;
      if (bus.mem_rd !== exp_rd) begin
        errors++;
        $display("FAIL %s_mem_rd cycle %0d got %b expected %b", name, cyc, bus.mem_rd, exp_rd);
      end
      if (bus.mem_rd === 1'b1) begin
        checks++;
        if (bus.mem_addr !== {addr[31:2], 2'b00}) begin
          errors++;
          $display("FAIL %s_rd_addr got %h expected %h", name, bus.mem_addr, {addr[31:2], 2'b00});
        end
      end
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        last_done_cycle = cycle_cnt;
        checks++;
        if (cyc != exp_lat || bus.misalign_err !== exp_err || bus.mem_we !== !exp_err) begin
          errors++;
          $display("FAIL %s_done latency %0d err %b we %b expected latency %0d err %b we %b",
                   name, cyc, bus.misalign_err, bus.mem_we, exp_lat, exp_err, !exp_err);
        end
      end else begin
        checks++;
        if (bus.misalign_err !== 1'b0 || bus.mem_we !== 1'b0) begin
          errors++;
          $display("FAIL %s_early cycle %0d err %b we %b expected 0 0", name, cyc, bus.misalign_err, bus.mem_we);
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout no done after %0d cycles expected latency %0d", name, cyc, exp_lat);
    end
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.done, bus.misalign_err, bus.mem_rd, bus.mem_we} !== 5'b0 ||
        bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs st/dn/er/rd/we=%b addr=%h wdata=%h expected all 0",
               {bus.stall, bus.done, bus.misalign_err, bus.mem_rd, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall stall=%b done=%b expected 1 0", bus.stall, bus.done);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_byte();
    mem[64] <= 32'h11223344;
    go_idle(1);
    run_req(2'b00, 32'h103, 32'h000000AB, 3, 1'b0, 32'hAB223344, "sb");
    go_idle(1);
  endtask

  task automatic test_half();
    mem[64] <= 32'h11223344;
    go_idle(1);
    run_req(2'b01, 32'h102, 32'hFFFFBEEF, 3, 1'b0, 32'hBEEF3344, "sh_hi");
    go_idle(1);
    mem[64] <= 32'h11223344;
    go_idle(1);
    run_req(2'b01, 32'h100, 32'hFFFFBEEF, 3, 1'b0, 32'h1122BEEF, "sh_lo");
    go_idle(1);
  endtask

  task automatic test_word();
    int rd0;
    rd0 = rd_count;
    run_req(2'b10, 32'h100, 32'hDEADBEEF, 1, 1'b0, 32'hDEADBEEF, "sw");
    go_idle(1);
    checks++;
    if (rd_count != rd0) begin
      errors++;
      $display("FAIL sw_no_read mem_rd pulses %0d expected 0", rd_count - rd0);
    end
  endtask

  task automatic test_errors();
    int we0;
    int rd0;
    we0 = we_count;
    rd0 = rd_count;
    run_req(2'b01, 32'h101, 32'h1234, 1, 1'b1, 32'h0, "sh_mis");
    run_req(2'b10, 32'h102, 32'h1234, 1, 1'b1, 32'h0, "sw_mis");
    run_req(2'b11, 32'h100, 32'h1234, 1, 1'b1, 32'h0, "size11");
    go_idle(1);
    checks++;
    if (we_count != we0 || rd_count != rd0) begin
      errors++;
      $display("FAIL err_no_access we %0d rd %0d expected 0 0", we_count - we0, rd_count - rd0);
    end
  endtask

  task automatic test_reset_mid();
    int we0;
    we0 = we_count;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h101;
    bus.req_wdata = 32'h77;
    @(posedge clk); #1;          // RD cycle
    @(posedge clk); #1;          // MRG cycle
    rst = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state !== 3'd0 || {bus.stall, bus.done, bus.misalign_err, bus.mem_rd, bus.mem_we} !== 5'b0 ||
        bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset state=%0d st/dn/er/rd/we=%b addr=%h wdata=%h expected 0",
               dut.state, {bus.stall, bus.done, bus.misalign_err, bus.mem_rd, bus.mem_we},
               bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (we_count != we0) begin
      errors++;
      $display("FAIL mid_reset_no_write mem_we pulses %0d expected 0", we_count - we0);
    end
    run_req(2'b10, 32'h108, 32'hCAFEF00D, 1, 1'b0, 32'hCAFEF00D, "sw_after_rst");
    go_idle(1);
  endtask

  task automatic test_back_to_back();
    int we0;
    int d1;
    mem[64] <= 32'h11223344;
    go_idle(1);
    we0 = we_count;
    run_req(2'b00, 32'h100, 32'h00000055, 3, 1'b0, 32'h11223355, "b2b_sb");
    d1 = last_done_cycle;
    run_req(2'b10, 32'h104, 32'h01020304, 1, 1'b0, 32'h01020304, "b2b_sw");
    checks++;
    if (last_done_cycle - d1 != 2) begin
      errors++;
      $display("FAIL b2b_accept done spacing %0d expected 2", last_done_cycle - d1);
    end
    go_idle(2);
    checks++;
    if (we_count - we0 != 2) begin
      errors++;
      $display("FAIL b2b_we_count got %0d expected 2", we_count - we0);
    end
  endtask

  task automatic test_random();
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expw;
    bit legal;
    for (int i = 0; i < 12; i++) begin
      size  = 2'($urandom_range(0, 3));
      addr  = 32'h100 + 32'($urandom_range(0, 63));
      wdata = $urandom;
      legal = is_legal(size, addr);
      expw  = model_word(mem[addr[9:2]], size, addr, wdata);
      run_req(size, addr, wdata, (!legal || size == 2'b10) ? 1 : 3, !legal, expw, "rand");
      go_idle(1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    test_reset();
    test_byte();
    test_half();
    test_word();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes got %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
